// File: rtl/updown_counter_ch.sv
// Parametrised up/down event counter with optional input synchroniser, edge detection,
// programmable step and limits (wrap or saturate), synchronous load and sticky limit flags.
module updown_counter_ch #(
    parameter int WIDTH       = 8,
    parameter int STEP_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 1,
    parameter int SATURATE    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              up_in,
    input  logic              down_in,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    input  logic [WIDTH-1:0]  upper_limit,
    input  logic [WIDTH-1:0]  lower_limit,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  count,
    output logic              at_max,
    output logic              at_min,
    output logic              overflow,
    output logic              underflow,
    output logic              last_dir
);

    logic up_sync, down_sync;
    logic up_event, down_event;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign up_sync   = up_in;
            assign down_sync = down_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] up_pipe, down_pipe;

            always_ff @(posedge clk) begin
                if (reset) begin
                    up_pipe   <= '0;
                    down_pipe <= '0;
                end else begin
                    up_pipe[0]   <= up_in;
                    down_pipe[0] <= down_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        up_pipe[i]   <= up_pipe[i-1];
                        down_pipe[i] <= down_pipe[i-1];
                    end
                end
            end

            assign up_sync   = up_pipe[SYNC_STAGES-1];
            assign down_sync = down_pipe[SYNC_STAGES-1];
        end
    endgenerate

    // Edge registers ignore enable so re-enabling with an input held high adds no event.
    generate
        if (EDGE_MODE != 0) begin : g_edge
            logic up_d, down_d;

            always_ff @(posedge clk) begin
                if (reset) begin
                    up_d   <= 1'b0;
                    down_d <= 1'b0;
                end else begin
                    up_d   <= up_sync;
                    down_d <= down_sync;
                end
            end

            assign up_event   = up_sync & ~up_d;
            assign down_event = down_sync & ~down_d;
        end else begin : g_level
            assign up_event   = up_sync;
            assign down_event = down_sync;
        end
    endgenerate

    logic             up_ev, dn_ev;
    logic [WIDTH:0]   step_ext, sum_ext, floor_ext;
    logic [WIDTH-1:0] next_count;
    logic             next_overflow, next_underflow, next_dir;

    assign up_ev = up_event & ~down_event;
    assign dn_ev = down_event & ~up_event;

    // One extra bit keeps the limit comparisons free of binary wrap-around.
    assign step_ext  = (WIDTH+1)'(step);
    assign sum_ext   = {1'b0, count} + step_ext;
    assign floor_ext = {1'b0, lower_limit} + step_ext;

    always_comb begin
        next_count     = count;
        next_overflow  = overflow & ~clr_flags;
        next_underflow = underflow & ~clr_flags;
        next_dir       = last_dir;
        if (load) begin
            next_count = load_value;
        end else if (enable && up_ev) begin
            next_dir = 1'b1;
            if (sum_ext <= {1'b0, upper_limit}) begin
                next_count = sum_ext[WIDTH-1:0];
            end else begin
                next_overflow = 1'b1;
                next_count    = (SATURATE != 0) ? upper_limit : lower_limit;
            end
        end else if (enable && dn_ev) begin
            next_dir = 1'b0;
            if ({1'b0, count} >= floor_ext) begin
                next_count = count - step_ext[WIDTH-1:0];
            end else begin
                next_underflow = 1'b1;
                next_count     = (SATURATE != 0) ? lower_limit : upper_limit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            last_dir  <= 1'b0;
        end else begin
            count     <= next_count;
            overflow  <= next_overflow;
            underflow <= next_underflow;
            last_dir  <= next_dir;
        end
    end

    assign at_max = (count >= upper_limit);
    assign at_min = (count <= lower_limit);

endmodule

// File: tb/tb_updown_counter_ch.sv
// Self-checking bench: three counter variants share one stimulus stream and are
// compared every cycle against an input-history model, plus hand-computed checkpoints.
module tb_updown_counter_ch;

    logic       clk = 1'b0;
    logic       reset, enable, up_in, down_in, load, clr_flags;
    logic [3:0] step;
    logic [7:0] load_value, upper_limit, lower_limit;

    logic [7:0] dCount [3];
    logic       dAtMax [3];
    logic       dAtMin [3];
    logic       dOv    [3];
    logic       dUn    [3];
    logic       dDir   [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Variant 0: direct level inputs, wrap.  1: 2-stage sync + edge, wrap.  2: direct level, saturate.
    updown_counter_ch #(.WIDTH(8), .STEP_W(4), .SYNC_STAGES(0), .EDGE_MODE(0), .SATURATE(0)) u0 (
        .clk(clk), .reset(reset), .enable(enable), .up_in(up_in), .down_in(down_in),
        .step(step), .load(load), .load_value(load_value), .upper_limit(upper_limit),
        .lower_limit(lower_limit), .clr_flags(clr_flags), .count(dCount[0]),
        .at_max(dAtMax[0]), .at_min(dAtMin[0]), .overflow(dOv[0]), .underflow(dUn[0]),
        .last_dir(dDir[0]));

    updown_counter_ch #(.WIDTH(8), .STEP_W(4), .SYNC_STAGES(2), .EDGE_MODE(1), .SATURATE(0)) u1 (
        .clk(clk), .reset(reset), .enable(enable), .up_in(up_in), .down_in(down_in),
        .step(step), .load(load), .load_value(load_value), .upper_limit(upper_limit),
        .lower_limit(lower_limit), .clr_flags(clr_flags), .count(dCount[1]),
        .at_max(dAtMax[1]), .at_min(dAtMin[1]), .overflow(dOv[1]), .underflow(dUn[1]),
        .last_dir(dDir[1]));

    updown_counter_ch #(.WIDTH(8), .STEP_W(4), .SYNC_STAGES(0), .EDGE_MODE(0), .SATURATE(1)) u2 (
        .clk(clk), .reset(reset), .enable(enable), .up_in(up_in), .down_in(down_in),
        .step(step), .load(load), .load_value(load_value), .upper_limit(upper_limit),
        .lower_limit(lower_limit), .clr_flags(clr_flags), .count(dCount[2]),
        .at_max(dAtMax[2]), .at_min(dAtMin[2]), .overflow(dOv[2]), .underflow(dUn[2]),
        .last_dir(dDir[2]));

    function automatic int syncOf(int i);
        return (i == 1) ? 2 : 0;
    endfunction

    function automatic bit edgeOf(int i);
        return (i == 1);
    endfunction

    function automatic bit satOf(int i);
        return (i == 2);
    endfunction

    // Model: remember every sampled input; an event at edge n looks back SYNC_STAGES edges,
    // and anything sampled at or before the latest reset edge reads as zero.
    bit hUp [0:4095];
    bit hDn [0:4095];
    int edgeN      = -1;
    int lastReset  = -1;
    bit modelValid = 1'b0;
    int mCount [3];
    bit mOv    [3];
    bit mUn    [3];
    bit mDir   [3];

    function automatic bit histVal(bit isUp, int m);
        if (m < 0 || m <= lastReset || m > 4095) return 1'b0;
        return isUp ? hUp[m] : hDn[m];
    endfunction

    always @(posedge clk) begin
        edgeN = edgeN + 1;
        if (edgeN <= 4095) begin
            hUp[edgeN] = up_in;
            hDn[edgeN] = down_in;
        end
        if (reset) begin
            lastReset  = edgeN;
            modelValid = 1'b1;
            for (int i = 0; i < 3; i++) begin
                mCount[i] = 0;
                mOv[i]    = 1'b0;
                mUn[i]    = 1'b0;
                mDir[i]   = 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                int  s;
                bit  ue, de, setOv, setUn;
                s = syncOf(i);
                if (edgeOf(i)) begin
                    ue = histVal(1'b1, edgeN - s) && !histVal(1'b1, edgeN - s - 1);
                    de = histVal(1'b0, edgeN - s) && !histVal(1'b0, edgeN - s - 1);
                end else begin
                    ue = histVal(1'b1, edgeN - s);
                    de = histVal(1'b0, edgeN - s);
                end
                setOv = 1'b0;
                setUn = 1'b0;
                if (load) begin
                    mCount[i] = int'(load_value);
                end else if (enable && ue && !de) begin
                    mDir[i] = 1'b1;
                    if (mCount[i] + int'(step) <= int'(upper_limit)) begin
                        mCount[i] = mCount[i] + int'(step);
                    end else begin
                        setOv     = 1'b1;
                        mCount[i] = satOf(i) ? int'(upper_limit) : int'(lower_limit);
                    end
                end else if (enable && de && !ue) begin
                    mDir[i] = 1'b0;
                    if (mCount[i] >= int'(lower_limit) + int'(step)) begin
                        mCount[i] = mCount[i] - int'(step);
                    end else begin
                        setUn     = 1'b1;
                        mCount[i] = satOf(i) ? int'(lower_limit) : int'(upper_limit);
                    end
                end
                mOv[i] = (mOv[i] && !clr_flags) || setOv;
                mUn[i] = (mUn[i] && !clr_flags) || setUn;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total = total + 1;
        if (actual !== expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (modelValid) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput($sformatf("u%0d.count", i), int'(dCount[i]), mCount[i]);
                checkOutput($sformatf("u%0d.at_max", i), int'(dAtMax[i]),
                            (mCount[i] >= int'(upper_limit)) ? 1 : 0);
                checkOutput($sformatf("u%0d.at_min", i), int'(dAtMin[i]),
                            (mCount[i] <= int'(lower_limit)) ? 1 : 0);
                checkOutput($sformatf("u%0d.overflow", i), int'(dOv[i]), int'(mOv[i]));
                checkOutput($sformatf("u%0d.underflow", i), int'(dUn[i]), int'(mUn[i]));
                checkOutput($sformatf("u%0d.last_dir", i), int'(dDir[i]), int'(mDir[i]));
            end
        end
    end

    // Drive one cycle's inputs, let the next rising edge consume them, then return just after it.
    task automatic applyStimulus(input logic rst, input logic en, input logic up, input logic dn,
                                 input logic [3:0] st, input logic ld, input logic [7:0] lv,
                                 input logic [7:0] hi, input logic [7:0] lo, input logic clr);
        reset       = rst;
        enable      = en;
        up_in       = up;
        down_in     = dn;
        step        = st;
        load        = ld;
        load_value  = lv;
        upper_limit = hi;
        lower_limit = lo;
        clr_flags   = clr;
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; up_in = 1'b0; down_in = 1'b0; step = 4'd1;
        load = 1'b0; load_value = 8'd0; upper_limit = 8'd255; lower_limit = 8'd0; clr_flags = 1'b0;
        #2;

        // Reset then level counting on the direct-input variant
        applyStimulus(1, 1, 0, 0, 1, 0, 0, 255, 0, 0);
        applyStimulus(1, 1, 0, 0, 1, 0, 0, 255, 0, 0);
        checkOutput("reset.count", int'(dCount[0]), 0);
        checkOutput("reset.overflow", int'(dOv[0]), 0);
        checkOutput("reset.last_dir", int'(dDir[0]), 0);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(0, 1, 1, 0, 1, 0, 0, 255, 0, 0);
            checkOutput($sformatf("level.count%0d", k), int'(dCount[0]), k);
        end
        checkOutput("level.last_dir", int'(dDir[0]), 1);
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 1, 1, 1, 0, 0, 255, 0, 0);
        checkOutput("both.hold", int'(dCount[0]), 5);

        // Edge mode with two-stage synchroniser
        applyStimulus(1, 1, 0, 0, 1, 0, 0, 255, 0, 0);
        applyStimulus(1, 1, 0, 0, 1, 0, 0, 255, 0, 0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 1, 1, 0, 1, 0, 0, 255, 0, 0);
            if (k == 1) checkOutput("edge.k+1", int'(dCount[1]), 0);
            if (k == 2) checkOutput("edge.k+2", int'(dCount[1]), 1);
        end
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 1, 0, 1, 0, 0, 255, 0, 0);
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 1, 0, 1, 0, 0, 255, 0, 0);
        checkOutput("edge.reenable", int'(dCount[1]), 1);
        applyStimulus(0, 1, 0, 0, 1, 0, 0, 255, 0, 0);

        // Wrap mode, limits 10..20, step 3
        applyStimulus(0, 1, 0, 0, 3, 1, 19, 20, 10, 1);
        checkOutput("wrap.load", int'(dCount[0]), 19);
        applyStimulus(0, 1, 1, 0, 3, 0, 0, 20, 10, 0);
        checkOutput("wrap.up.count", int'(dCount[0]), 10);
        checkOutput("wrap.up.overflow", int'(dOv[0]), 1);
        applyStimulus(0, 1, 0, 1, 3, 0, 0, 20, 10, 0);
        checkOutput("wrap.dn.count", int'(dCount[0]), 20);
        checkOutput("wrap.dn.underflow", int'(dUn[0]), 1);
        applyStimulus(0, 1, 0, 0, 3, 0, 0, 20, 10, 1);
        checkOutput("clr.overflow", int'(dOv[0]), 0);
        checkOutput("clr.underflow", int'(dUn[0]), 0);

        // Saturate mode, limits 10..20, step 4
        applyStimulus(0, 1, 0, 0, 4, 1, 18, 20, 10, 0);
        applyStimulus(0, 1, 1, 0, 4, 0, 0, 20, 10, 0);
        checkOutput("sat.up.count", int'(dCount[2]), 20);
        checkOutput("sat.up.overflow", int'(dOv[2]), 1);
        checkOutput("sat.at_max", int'(dAtMax[2]), 1);
        applyStimulus(0, 1, 0, 0, 4, 1, 12, 20, 10, 0);
        applyStimulus(0, 1, 0, 1, 4, 0, 0, 20, 10, 0);
        checkOutput("sat.dn.count", int'(dCount[2]), 10);
        checkOutput("sat.dn.underflow", int'(dUn[2]), 1);
        checkOutput("sat.at_min", int'(dAtMin[2]), 1);

        // Priority and clear race
        applyStimulus(0, 1, 1, 0, 1, 1, 8'h55, 255, 0, 1);
        checkOutput("prio.load", int'(dCount[0]), 8'h55);
        applyStimulus(0, 1, 1, 0, 1, 0, 0, 8'h55, 0, 1);
        checkOutput("race.overflow", int'(dOv[0]), 1);
        checkOutput("race.count", int'(dCount[0]), 0);
        applyStimulus(0, 1, 0, 0, 1, 1, 8'h40, 255, 0, 0);
        checkOutput("load.count", int'(dCount[0]), 8'h40);
        checkOutput("load.keeps_flag", int'(dOv[0]), 1);
        applyStimulus(1, 1, 1, 0, 1, 0, 0, 255, 0, 0);
        checkOutput("midreset.count", int'(dCount[0]), 0);
        checkOutput("midreset.overflow", int'(dOv[0]), 0);

        // Zero step still records direction
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 255, 0, 0);
        checkOutput("step0.up.count", int'(dCount[0]), 0);
        checkOutput("step0.up.dir", int'(dDir[0]), 1);
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 255, 0, 0);
        checkOutput("step0.dn.dir", int'(dDir[0]), 0);
        checkOutput("step0.dn.underflow", int'(dUn[0]), 0);
        applyStimulus(0, 1, 0, 0, 1, 0, 0, 255, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 0, 0, 255, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
